// File: rtl/jk_pkg.sv
// Shared JK encodings and the excitation helper used by the modulo counter.
package jk_pkg;

  // {J,K} control encodings
  localparam logic [1:0] HOLD = 2'b00;
  localparam logic [1:0] RST  = 2'b01;
  localparam logic [1:0] SET  = 2'b10;
  localparam logic [1:0] TOG  = 2'b11;

  // Minimal excitation that moves a cell from cur to nxt; never returns TOG.
  function automatic logic [1:0] jk_excite(input logic cur, input logic nxt);
    return {nxt & ~cur, ~nxt & cur};
  endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with synchronous active-high reset to 0.
module jk_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qn
);

  logic q_q;
  logic q_d;

  // Classic JK characteristic: hold / reset / set / toggle.
  always_comb begin
    q_d = q_q;
    case ({j, k})
      HOLD:    q_d = q_q;
      RST:     q_d = 1'b0;
      SET:     q_d = 1'b1;
      TOG:     q_d = ~q_q;
      default: q_d = q_q;
    endcase
  end

  // Storage bit; reset dominates any J/K drive.
  always_ff @(posedge clk) begin
    if (rst) q_q <= 1'b0;
    else     q_q <= q_d;
  end

  assign q  = q_q;
  assign qn = ~q_q;

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-MODULUS up/down counter whose state lives only in a bank of JK cells.
// This level computes the next count, derives per-bit J/K drive and tc.
module jk_mod_counter
  import jk_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             tc
);

  // One extra bit so comparisons and +/-1 never rely on 2**WIDTH overflow.
  localparam logic [WIDTH:0] MOD_X = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0] MAX_X = (WIDTH+1)'(MODULUS - 1);

  logic [WIDTH:0]   q_x;
  logic [WIDTH:0]   din_x;
  logic [WIDTH-1:0] nxt_d;
  logic [WIDTH-1:0] j_w;
  logic [WIDTH-1:0] k_w;

  assign q_x   = {1'b0, q};
  assign din_x = {1'b0, din};

  // Next-count selection: load (with clamp) beats count; illegal states recover to 0.
  always_comb begin
    nxt_d = q;
    if (load) begin
      nxt_d = (din_x < MOD_X) ? din : WIDTH'(MAX_X);
    end else if (en) begin
      if (q_x >= MOD_X)     nxt_d = '0;
      else if (up)          nxt_d = (q_x == MAX_X) ? '0 : WIDTH'(q_x + 1'b1);
      else                  nxt_d = (q_x == '0) ? WIDTH'(MAX_X) : WIDTH'(q_x - 1'b1);
    end
  end

  // Per-bit excitation: unchanged bits get HOLD, so en=0 drives J=K=0 everywhere.
  always_comb begin
    j_w = '0;
    k_w = '0;
    for (int i = 0; i < WIDTH; i++) begin
      {j_w[i], k_w[i]} = jk_excite(q[i], nxt_d[i]);
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell u_cell (
      .clk (clk),
      .rst (rst),
      .j   (j_w[i]),
      .k   (k_w[i]),
      .q   (q[i]),
      .qn  (qn[i])
    );
  end

  // High in exactly the cycle whose edge wraps; stays low for out-of-range q.
  assign tc = en & ~load & ((up & (q_x == MAX_X)) | (~up & (q_x == '0)));

endmodule

// File: tb/tb_jk_mod_counter.sv
// Scoreboard bench for jk_mod_counter (WIDTH=4, MODULUS=10).
module tb_jk_mod_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b0;
  logic       load = 1'b0;
  logic [3:0] din = 4'd0;
  logic [3:0] q;
  logic [3:0] qn;
  logic       tc;

  int n_total = 0;
  int n_pass  = 0;
  int n_step  = 0;

  typedef struct {
    logic       exp_tc;
    logic [3:0] exp_q;
    bit         hold;
  } exp_t;

  exp_t sb[$];

  jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .up   (up),
    .load (load),
    .din  (din),
    .q    (q),
    .qn   (qn),
    .tc   (tc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s step=%0d got=%b expected=%b", name, n_step, got, exp);
  endtask

  // Drive one cycle of inputs on the falling edge and queue its expected response.
  task automatic step(input logic r, input logic e, input logic u, input logic l,
                      input logic [3:0] d, input logic etc, input logic [3:0] eq,
                      input bit h);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; up = u; load = l; din = d;
    x.exp_tc = etc; x.exp_q = eq; x.hold = h;
    sb.push_back(x);
  endtask

  // Monitor: pre-edge checks of tc and J/K drive, post-edge checks of q/qn.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_step++;
        chk("tc", {3'b000, tc}, {3'b000, e.exp_tc});
        chk("no_toggle", dut.j_w & dut.k_w, 4'b0000);
        if (e.hold) begin
          chk("hold_j", dut.j_w, 4'b0000);
          chk("hold_k", dut.k_w, 4'b0000);
        end
        @(posedge clk);
        #1;
        chk("q", q, e.exp_q);
        chk("qn", qn, ~e.exp_q);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout step=%0d got=running expected=finished", n_step);
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] up_q  [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                               4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
    logic       up_tc [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                               1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    // reset with load/en active; load masks tc
    step(1, 1, 1, 1, 4'd5, 0, 4'd0, 0);
    step(1, 1, 1, 1, 4'd5, 0, 4'd0, 0);

    // up count through wrap
    for (int i = 0; i < 12; i++) step(0, 1, 1, 0, 4'd0, up_tc[i], up_q[i], 0);

    // down count through wrap
    step(0, 0, 0, 1, 4'd1, 0, 4'd1, 0);
    step(0, 1, 0, 0, 4'd0, 0, 4'd0, 0);
    step(0, 1, 0, 0, 4'd0, 1, 4'd9, 0);
    step(0, 1, 0, 0, 4'd0, 0, 4'd8, 0);

    // load and clamp; load at q=9 with en/up suppresses tc
    step(0, 0, 1, 1, 4'd7,  0, 4'd7, 0);
    step(0, 0, 1, 1, 4'd13, 0, 4'd9, 0);
    step(0, 1, 1, 1, 4'd3,  0, 4'd3, 0);
    step(0, 0, 0, 1, 4'd15, 0, 4'd9, 0);

    // hold at 6 with direction toggling
    step(0, 0, 0, 1, 4'd6, 0, 4'd6, 0);
    for (int i = 0; i < 5; i++) step(0, 0, logic'(i & 1), 0, 4'd0, 0, 4'd6, 1);

    // reset mid-count at 8, then resume
    step(0, 0, 1, 1, 4'd8, 0, 4'd8, 0);
    step(1, 1, 1, 0, 4'd0, 0, 4'd0, 0);
    step(0, 1, 1, 0, 4'd0, 0, 4'd1, 0);

    // reset while tc=1: tc still visible, no wrap; then down wrap from 0
    step(0, 0, 1, 1, 4'd9, 0, 4'd9, 0);
    step(1, 1, 1, 0, 4'd0, 1, 4'd0, 0);
    step(0, 1, 0, 0, 4'd0, 1, 4'd9, 0);

    @(negedge clk);
    rst = 0; en = 0; load = 0;
    repeat (3) @(negedge clk);
    n_total++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL drain got=%0d expected=0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
